sram_loop_addr_gen: RTL
=======================

SRAM_LOOP_ADDR_GEN -- requirements
Module: sram_loop_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 5: width of addr; matches the single_port_sram DEPTH it drives (log2 DEPTH).
REQ-002 Parameter N_OUTER, default 4: outer loop trip count, >= 1.
REQ-003 Parameter N_INNER, default 8: inner loop trip count, >= 1.
REQ-004 Parameter STRIDE_OUTER, default 8: address increment per outer iteration.
REQ-005 Parameter STRIDE_INNER, default 1: address increment per inner iteration.
REQ-006 Parameter BASE, default 0: first address issued.
REQ-007 Parameter II, default 1: cycles between issues, >= 1.
REQ-008 Parameter WRITE_MODE, default 0: 0 = drive ren, 1 = drive wen.
REQ-009 clk  in  1  sole clock; all state on rising edge.
REQ-010 rst  in  1  asynchronous, active-low reset.
REQ-011 start  in  1  single-cycle pulse to begin one full loop nest.
REQ-012 stall  in  1  freezes issue while high.
REQ-013 addr  out  ADDR_W  SRAM address for the current access.
REQ-014 ren  out  1  SRAM read strobe.
REQ-015 wen  out  1  SRAM write strobe.
REQ-016 rd_valid  out  1  high in the cycle the SRAM q output holds read data.
REQ-017 busy  out  1  high from the cycle after an accepted start until done.
REQ-018 done  out  1  one-cycle pulse after the final access is issued, or after the final read data is valid in read mode.

Function
REQ-019 FSM states: IDLE, ISSUE, GAP, DRAIN.
- IDLE --start--> ISSUE.
- ISSUE --(II>1)--> GAP for II-1 cycles, then ISSUE.
- After the last access, the FSM goes to DRAIN in read mode and to IDLE in write mode.
- DRAIN --1 cycle--> IDLE.
REQ-020 An access is issued only in an ISSUE cycle with stall low; a stalled ISSUE cycle stays in ISSUE and asserts neither strobe.
REQ-021 The GAP count holds while stall is high.
REQ-022 Issue order is row-major: i = 0..N_OUTER-1 (outer), j = 0..N_INNER-1 (inner).
REQ-023 addr = (BASE + i*STRIDE_OUTER + j*STRIDE_INNER) mod 2^ADDR_W, computed with incremental accumulators (no multiplier); wrap-around past 2^ADDR_W is silent.
REQ-024 ren = issue & !WRITE_MODE; wen = issue & WRITE_MODE; ren and wen are never high together.
REQ-025 addr is held stable when no access is issued.
REQ-026 rd_valid equals ren delayed by exactly one cycle; it is zero in write mode.
REQ-027 done pulses the cycle after the last wen in write mode, or in the DRAIN cycle (coincident with the last rd_valid) in read mode.
REQ-028 busy deasserts in the same cycle done pulses.
REQ-029 start while busy is ignored.
REQ-030 start in the done cycle is accepted.
REQ-031 Total accesses per start = N_OUTER*N_INNER; with stall low, the last issue occurs II*(N_OUTER*N_INNER - 1) cycles after the first.
REQ-032 The first issue occurs the cycle after start.
REQ-033 N_OUTER = N_INNER = 1 issues exactly one access.

Reset
REQ-034 rst low forces, asynchronously: state IDLE; ren, wen, rd_valid, busy, done = 0; addr = BASE; loop counters = 0.
REQ-035 rst asserted mid-nest abandons the nest; no further access is issued after rst deasserts until a new start.

Structure
REQ-036 The FSM state encoding and a clog2-based width constant live in the shared package used by all builtins.
REQ-037 One sub-module, loop_level_counter (count, wrap pulse, stride accumulator), is instantiated twice: inner and outer.

Verification
REQ-038 Defaults, read mode: start, stall = 0 -> ren high for 32 consecutive cycles, addr 0,1,...,31; rd_valid lags ren by 1; done in the cycle of the 32nd rd_valid.
REQ-039 II = 3, N_OUTER = 2, N_INNER = 2, STRIDE_OUTER = 10, STRIDE_INNER = 2 -> addr 0,2,10,12 on cycles 1,4,7,10 after start.
REQ-040 stall high for 5 cycles after the 3rd issue -> no strobes during the stall; sequence resumes at addr 3 with no skip or duplicate.
REQ-041 ADDR_W = 3, BASE = 6, N_OUTER = 1, N_INNER = 4 -> addr 6,7,0,1.
REQ-042 rst pulsed low after the 10th issue, then start -> outputs cleared immediately; the new run begins at addr BASE.
REQ-043 WRITE_MODE = 1 with start re-pulsed during busy and again in the done cycle -> the busy-time start is ignored; exactly two full runs of wen occur; rd_valid stays 0 throughout.

Source files
------------

// File: rtl/sram_loop_addr_gen_pkg.sv
// Shared FSM encoding and width helper for the SRAM loop address generator.
package sram_loop_addr_gen_pkg;

  // Four FSM states need $clog2(4) = 2 state bits.
  localparam int STATE_W = $clog2(4);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Bits needed to hold a count of 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_loop_addr_gen_loop_level_counter.sv
// One loop level: trip counter, wrap pulse on the last step, and a stride
// accumulator that rewinds to zero when the level wraps.
module loop_level_counter
  import sram_loop_addr_gen_pkg::*;
#(
  parameter int N      = 1,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              clear,
  output logic              wrap,
  output logic [ADDR_W-1:0] acc
);

  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count;

  assign wrap = step & (count == LAST);

  // Advance count and accumulator on each step; rewind on wrap or clear.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset branch is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      acc   <= '0;
    end else if (clear) begin
      count <= '0;
      acc   <= '0;
    end else if (step) begin
      if (count == LAST) begin
        count <= '0;
        acc   <= '0;
      end else begin
        count <= count + CW'(1);
        acc   <= acc + ADDR_W'(STRIDE);
      end
    end
  end

endmodule

// File: rtl/sram_loop_addr_gen.sv
// Two-level loop address generator driving a single-port SRAM. Issues
// N_OUTER*N_INNER accesses in row-major order, one every II cycles, with a
// stall input that freezes issue and the inter-issue gap.
module sram_loop_addr_gen
  import sram_loop_addr_gen_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int N_OUTER      = 4,
  parameter int N_INNER      = 8,
  parameter int STRIDE_OUTER = 8,
  parameter int STRIDE_INNER = 1,
  parameter int BASE         = 0,
  parameter int II           = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic              ren,
  output logic              wen,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam int            GW       = cnt_w(II);
  localparam logic [GW-1:0] GAP_LOAD = GW'((II > 1) ? II - 2 : 0);
  localparam bit            IS_WRITE = (WRITE_MODE != 0);

  state_e            state, state_nxt;
  logic [GW-1:0]     gap_cnt;
  logic              fire, accept, inner_wrap, last;
  logic [ADDR_W-1:0] inner_acc, outer_acc, cur_addr, addr_hold;

  // An access happens only in an unstalled ISSUE cycle.
  assign fire   = (state == S_ISSUE) & ~stall;
  // A new nest may begin from IDLE or from the DRAIN (done) cycle.
  assign accept = start & ((state == S_IDLE) | (state == S_DRAIN));

  loop_level_counter #(.N(N_INNER), .STRIDE(STRIDE_INNER), .ADDR_W(ADDR_W)) u_inner (
    .clk   (clk),
    .rst   (rst),
    .step  (fire),
    .clear (accept),
    .wrap  (inner_wrap),
    .acc   (inner_acc)
  );

  loop_level_counter #(.N(N_OUTER), .STRIDE(STRIDE_OUTER), .ADDR_W(ADDR_W)) u_outer (
    .clk   (clk),
    .rst   (rst),
    .step  (inner_wrap),
    .clear (accept),
    .wrap  (last),
    .acc   (outer_acc)
  );

  // Wrap-around past 2^ADDR_W is intentional and silent.
  assign cur_addr = ADDR_W'(BASE) + inner_acc + outer_acc;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (fire) begin
          if (last)        state_nxt = IS_WRITE ? S_IDLE : S_DRAIN;
          else if (II > 1) state_nxt = S_GAP;
        end
      end
      S_GAP:   if (!stall && gap_cnt == '0) state_nxt = S_ISSUE;
      S_DRAIN: state_nxt = start ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Gap countdown: loaded on each issue, frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if (fire) begin
      gap_cnt <= GAP_LOAD;
    end else if (state == S_GAP && !stall && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // Remember the last issued address so addr stays put between accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      addr_hold <= ADDR_W'(BASE);
    else if (fire) addr_hold <= cur_addr;
  end

  // Read data valid one cycle after ren; done one cycle after the last issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= ren;
      done     <= fire & last;
    end
  end

  assign addr = fire ? cur_addr : addr_hold;
  assign ren  = fire & ~IS_WRITE;
  assign wen  = fire & IS_WRITE;
  assign busy = (state == S_ISSUE) | (state == S_GAP);

endmodule
